// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported 32-bit memory.
// Each access runs IDLE -> ACCESS -> WAIT -> DONE; out-of-range addresses
// skip straight from IDLE to DONE with an error and never touch memory.
module mem_arbiter #(
  parameter int MEM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,

  output logic        mem_rd,
  output logic        mem_wn,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  // Full 32-bit unsigned limit so huge addresses cannot alias into range.
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state;
  logic        last;       // port served most recently
  logic        owner;      // port owning the current transaction
  logic        err_flag;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        win;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        in_access;
  logic        in_done;

  // Round-robin winner: on a tie the port not served last takes the bus.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    win = 1'b0;
    if (p0_req && p1_req) begin
      win = ~last;
    end else if (p1_req) begin
      win = 1'b1;
    end
  end

  assign win_we    = win ? p1_we    : p0_we;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;

  // Sequencer: latch the winner's operands, step through the access phases
  // and capture read data for the owner on the edge closing WAIT.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      err_flag  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            owner     <= win;
            last      <= win;
            lat_we    <= win_we;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            if (win_addr >= MEM_LIMIT) begin
              err_flag <= 1'b1;
              state    <= S_DONE;
            end else begin
              err_flag <= 1'b0;
              state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!lat_we) begin
            if (owner) p1_rdata <= mem_rdata;
            else       p0_rdata <= mem_rdata;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          err_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state only; the bus is quiet outside ACCESS.
  assign in_access = (state == S_ACCESS);
  assign in_done   = (state == S_DONE);

  assign mem_rd    = in_access & ~lat_we;
  assign mem_wn    = in_access &  lat_we;
  assign mem_addr  = in_access ? lat_addr  : '0;
  assign mem_wdata = in_access ? lat_wdata : '0;

  assign p0_gnt    = in_access & ~owner;
  assign p1_gnt    = in_access &  owner;
  assign p0_done   = in_done   & ~owner;
  assign p1_done   = in_done   &  owner;
  assign p0_err    = p0_done   &  err_flag;
  assign p1_err    = p1_done   &  err_flag;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written sequences for round-robin, reset abort, back-to-back and
// operand changes mid-transaction. Includes a simple registered memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_rd, mem_wn;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_rd(mem_rd), .mem_wn(mem_wn), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: index with the low 11 bits so a stray write to an
  // out-of-range address lands on a real word and becomes visible.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_wn) mem[mem_addr[10:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[10:0]];
  end

  // Bus and completion monitor, sampling pre-edge values.
  int          cyc = 0;
  int          rd_cnt = 0, wn_cnt = 0, both_cnt = 0, done_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  always @(posedge clk) begin
    cyc++;
    if (mem_rd) rd_cnt++;
    if (mem_wn) begin
      wn_cnt++;
      last_waddr = mem_addr;
      last_wdata = mem_wdata;
    end
    if (mem_rd && mem_wn) both_cnt++;
    if (p0_done || p1_done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // One transaction from an idle arbiter; returns latency in cycles from the
  // sampling edge to the done cycle (0 if done never arrives), the err bit
  // seen with done and whether gnt showed up in the first cycle.
  task automatic run_txn(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic err,
                         output logic gnt1);
    lat  = 0;
    err  = 1'b0;
    gnt1 = 1'b0;
    @(negedge clk);
    drive(port, 1'b1, we, addr, wdata);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) gnt1 = (port == 0) ? p0_gnt : p1_gnt;
      if ((port == 0) ? p0_done : p1_done) begin
        lat = i;
        err = (port == 0) ? p0_err : p1_err;
        break;
      end
    end
    drive(port, 1'b0, 1'b0, '0, '0);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd0;
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int          lat, rd0, wn0, d0, d1, dbefore;
    logic        err, gnt1;
    int          gcyc [4], gport [4], dcyc [4], dport [4];
    int          ng, nd, t0;

    for (int i = 0; i < 2048; i++) mem[i] = '0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);

    vecs[0]  = '{1, 1'b1, 32'd5,         32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{0, 1'b0, 32'd5,         32'h0,        1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{0, 1'b1, 32'd0,         32'h12345678, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1, 1'b1, 32'd2048,      32'h0BAD0BAD, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'd0,         32'h0,        1'b0, 32'h12345678, 32'h0};
    vecs[5]  = '{1, 1'b1, 32'd2047,      32'hA5A5A5A5, 1'b0, 32'h12345678, 32'h0};
    vecs[6]  = '{1, 1'b0, 32'd2047,      32'h0,        1'b0, 32'h12345678, 32'hA5A5A5A5};
    vecs[7]  = '{0, 1'b0, 32'h80000005,  32'h0,        1'b1, 32'h12345678, 32'hA5A5A5A5};
    vecs[8]  = '{1, 1'b0, 32'hFFFFFFFF,  32'h0,        1'b1, 32'h12345678, 32'hA5A5A5A5};
    vecs[9]  = '{0, 1'b0, 32'd2047,      32'h0,        1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[10] = '{1, 1'b0, 32'd5,         32'h0,        1'b0, 32'hA5A5A5A5, 32'hDEADBEEF};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_strobes", {30'b0, mem_rd, mem_wn}, 32'h0);
    check("reset_gnt_done", {28'b0, p0_gnt, p1_gnt, p0_done, p1_done}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_p0_rdata", p0_rdata, 32'h0);
    check("reset_p1_rdata", p1_rdata, 32'h0);
    rst_n = 1'b1;

    // Vector table: single transactions, other port idle
    foreach (vecs[i]) begin
      rd0 = rd_cnt;
      wn0 = wn_cnt;
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, gnt1);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_err ? 1 : 3);
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_gnt", i), {31'b0, gnt1}, {31'b0, ~vecs[i].exp_err});
      check($sformatf("v%0d_rd_strobes", i), rd_cnt - rd0,
            (!vecs[i].exp_err && !vecs[i].we) ? 1 : 0);
      check($sformatf("v%0d_wn_strobes", i), wn_cnt - wn0,
            (!vecs[i].exp_err && vecs[i].we) ? 1 : 0);
      check($sformatf("v%0d_p0_rdata", i), p0_rdata, vecs[i].exp_rd0);
      check($sformatf("v%0d_p1_rdata", i), p1_rdata, vecs[i].exp_rd1);
    end

    // Round robin after reset: both ports hold req; first edge out of reset
    // must already accept a request.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'd5, '0);
    drive(1, 1'b1, 1'b0, 32'd2047, '0);
    t0 = cyc;
    ng = 0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      gcyc[k] = -1; gport[k] = -1; dcyc[k] = -1; dport[k] = -1;
    end
    for (int i = 0; i < 24 && nd < 4; i++) begin
      @(negedge clk);
      if ((p0_gnt || p1_gnt) && ng < 4) begin
        gcyc[ng] = cyc - t0; gport[ng] = p1_gnt ? 1 : 0; ng++;
      end
      if ((p0_done || p1_done) && nd < 4) begin
        dcyc[nd] = cyc - t0; dport[nd] = p1_done ? 1 : 0; nd++;
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_gnt%0d_port", k), gport[k], k % 2);
      check($sformatf("rr_gnt%0d_cycle", k), gcyc[k], 1 + 4 * k);
      check($sformatf("rr_done%0d_port", k), dport[k], k % 2);
      check($sformatf("rr_done%0d_cycle", k), dcyc[k], 3 + 4 * k);
    end
    check("rr_p0_rdata", p0_rdata, 32'hDEADBEEF);
    check("rr_p1_rdata", p1_rdata, 32'hA5A5A5A5);

    // Reset on the edge that ends ACCESS of a read: abort, no done
    @(negedge clk);
    @(negedge clk);
    dbefore = done_cnt;
    drive(0, 1'b1, 1'b0, 32'd2047, '0);
    @(negedge clk);
    check("abort_gnt", {31'b0, p0_gnt}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_strobes_gnt_done",
          {26'b0, mem_rd, mem_wn, p0_gnt, p1_gnt, p0_done, p1_done}, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_p0_rdata", p0_rdata, 32'h0);
    check("abort_p1_rdata", p1_rdata, 32'h0);
    drive(0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt - dbefore, 0);
    check("abort_rdata_stays", p0_rdata, 32'h0);

    // Back-to-back on p0: write 7 = 1, then read 7 with req held
    d0 = -1;
    d1 = -1;
    drive(0, 1'b1, 1'b1, 32'd7, 32'h1);
    t0 = cyc;
    for (int i = 0; i < 16 && d1 < 0; i++) begin
      @(negedge clk);
      if (p0_done) begin
        if (d0 < 0) begin
          d0 = cyc - t0;
          drive(0, 1'b1, 1'b0, 32'd7, 32'h0);
        end else begin
          d1 = cyc - t0;
        end
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    check("b2b_spacing", d1 - d0, 4);
    check("b2b_p0_rdata", p0_rdata, 32'h1);

    // Operands change during WAIT of a p1 write
    @(negedge clk);
    wn0 = wn_cnt;
    drive(1, 1'b1, 1'b1, 32'd9, 32'h0BADF00D);
    @(negedge clk);
    check("opchg_gnt", {31'b0, p1_gnt}, 32'h1);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'd10, 32'h0);
    @(negedge clk);
    check("opchg_done", {30'b0, p1_done, p1_err}, 32'h2);
    drive(1, 1'b0, 1'b0, '0, '0);
    check("opchg_wn_count", wn_cnt - wn0, 1);
    check("opchg_waddr", last_waddr, 32'd9);
    check("opchg_wdata", last_wdata, 32'h0BADF00D);
    run_txn(1, 1'b0, 32'd9, '0, lat, err, gnt1);
    check("opchg_read9", p1_rdata, 32'h0BADF00D);
    run_txn(1, 1'b0, 32'd10, '0, lat, err, gnt1);
    check("opchg_read10", p1_rdata, 32'h0);

    check("never_rd_and_wn", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
